// File: rtl/btn_latch_pkg.sv
// Shared constants for the button set/reset latch bank: both-pressed
// resolution modes and the default debounce window.
package btn_latch_pkg;
    localparam int MODE_RESET_WINS   = 0;
    localparam int MODE_SET_WINS     = 1;
    localparam int MODE_HOLD         = 2;
    localparam int DB_CYCLES_DEFAULT = 270000;
endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a counter-based debouncer for one
// raw active-low button; pressed is the inverted debounced level.
module btn_debounce
    import btn_latch_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic pressed
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync1_q;
    logic          sync2_q;
    logic          db_q;
    logic          db_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Debounce next state: count consecutive mismatch cycles, accept the new level at the last one.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d  = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Synchroniser, counter and debounced level registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            db_q    <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pressed = ~db_q;
endmodule

// File: rtl/btn_latch_bank.sv
// Bank of independent debounced set/reset latches with complement and
// one-cycle change-pulse outputs.
module btn_latch_bank
    import btn_latch_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int BOTH_MODE = MODE_RESET_WINS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_set_n,
    input  logic [N_CH-1:0] btn_rst_n,
    output logic [N_CH-1:0] q,
    output logic [N_CH-1:0] q_n,
    output logic [N_CH-1:0] changed
);
    logic [N_CH-1:0] set_pr_s;
    logic [N_CH-1:0] rst_pr_s;
    logic [N_CH-1:0] q_q;
    logic [N_CH-1:0] q_d;
    logic [N_CH-1:0] q_n_q;
    logic [N_CH-1:0] changed_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_set_db (
            .clk    (clk),
            .rst    (rst),
            .btn_n  (btn_set_n[g]),
            .pressed(set_pr_s[g])
        );
        btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_rst_db (
            .clk    (clk),
            .rst    (rst),
            .btn_n  (btn_rst_n[g]),
            .pressed(rst_pr_s[g])
        );
    end

    // Latch next state per channel; unknown modes fall back to reset-wins.
    always_comb begin
        q_d = q_q;
        for (int i = 0; i < N_CH; i++) begin
            if (set_pr_s[i] && rst_pr_s[i]) begin
                case (BOTH_MODE)
                    MODE_SET_WINS: q_d[i] = 1'b1;
                    MODE_HOLD:     q_d[i] = q_q[i];
                    default:       q_d[i] = 1'b0;
                endcase
            end else if (set_pr_s[i]) begin
                q_d[i] = 1'b1;
            end else if (rst_pr_s[i]) begin
                q_d[i] = 1'b0;
            end else begin
                q_d[i] = q_q[i];
            end
        end
    end

    // Latch state, its complement and the change pulse all register on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q       <= '0;
            q_n_q     <= '1;
            changed_q <= '0;
        end else begin
            q_q       <= q_d;
            q_n_q     <= ~q_d;
            changed_q <= q_d ^ q_q;
        end
    end

    assign q       = q_q;
    assign q_n     = q_n_q;
    assign changed = changed_q;
endmodule

// File: tb/tb_btn_latch_bank.sv
// Directed bench: three instances (reset-wins, set-wins, hold) share the
// same button stimulus with a short debounce window of 4 cycles.
module tb_btn_latch_bank;
    logic       clk;
    logic       rst;
    logic [1:0] set_n;
    logic [1:0] rst_n;
    logic [1:0] q0, qn0, ch0;
    logic [1:0] q1, qn1, ch1;
    logic [1:0] q2, qn2, ch2;
    int         vectors;
    int         errs;
    int         trans;
    int         pulses;
    logic       prev_q;

    btn_latch_bank #(.N_CH(2), .DB_CYCLES(4), .BOTH_MODE(0)) u0 (
        .clk(clk), .rst(rst), .btn_set_n(set_n), .btn_rst_n(rst_n),
        .q(q0), .q_n(qn0), .changed(ch0));
    btn_latch_bank #(.N_CH(2), .DB_CYCLES(4), .BOTH_MODE(1)) u1 (
        .clk(clk), .rst(rst), .btn_set_n(set_n), .btn_rst_n(rst_n),
        .q(q1), .q_n(qn1), .changed(ch1));
    btn_latch_bank #(.N_CH(2), .DB_CYCLES(4), .BOTH_MODE(2)) u2 (
        .clk(clk), .rst(rst), .btn_set_n(set_n), .btn_rst_n(rst_n),
        .q(q2), .q_n(qn2), .changed(ch2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        vectors = 0;
        errs    = 0;
        rst     = 1'b1;
        set_n   = 2'b11;
        rst_n   = 2'b11;
        tick(3);
        check("reset_q", q0, 2'b00);
        check("reset_qn", qn0, 2'b11);
        check("reset_changed", ch0, 2'b00);
        check("reset_q_m1", q1, 2'b00);

        rst = 1'b0;
        tick(1);
        check("post_reset_changed", ch0, 2'b00);

        // Short glitch of 3 cycles must be filtered.
        set_n[0] = 1'b0;
        tick(3);
        set_n[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("glitch_changed", ch0, 2'b00);
        end
        check("glitch_q", q0, 2'b00);

        // Clean set press: q rises on edge 7.
        set_n[0] = 1'b0;
        tick(6);
        check("set_lat_edge6", q0, 2'b00);
        tick(1);
        check("set_lat_edge7", q0, 2'b01);
        check("set_qn", qn0, 2'b10);
        check("set_changed", ch0, 2'b01);
        tick(1);
        check("set_changed_end", ch0, 2'b00);
        set_n[0] = 1'b1;
        tick(8);
        check("set_release_hold", q0, 2'b01);

        // Both pressed on channel 0 with q[0]=1.
        set_n[0] = 1'b0;
        rst_n[0] = 1'b0;
        tick(7);
        check("both_m0", q0, 2'b00);
        check("both_m1", q1, 2'b01);
        check("both_m2", q2, 2'b01);
        set_n[0] = 1'b1;
        rst_n[0] = 1'b1;
        tick(8);

        // Bring u0 to q=10, then set ch0 and reset ch1 together.
        set_n[1] = 1'b0;
        tick(7);
        set_n[1] = 1'b1;
        tick(8);
        check("pre_simul_q", q0, 2'b10);
        set_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        tick(6);
        check("simul_edge6", q0, 2'b10);
        tick(1);
        check("simul_q", q0, 2'b01);
        check("simul_changed", ch0, 2'b11);
        check("simul_qn", qn0, 2'b10);
        tick(1);
        check("simul_changed_end", ch0, 2'b00);
        set_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        tick(8);

        // Clear ch0, then reset in the middle of a set press.
        rst_n[0] = 1'b0;
        tick(7);
        rst_n[0] = 1'b1;
        tick(8);
        check("clear_q", q0, 2'b00);
        set_n[0] = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
        check("midrst_q", q0, 2'b00);
        check("midrst_qn", qn0, 2'b11);
        rst = 1'b0;
        tick(6);
        check("midrst_edge6", q0, 2'b00);
        tick(1);
        check("midrst_edge7", q0, 2'b01);
        set_n[0] = 1'b1;
        tick(8);

        // Bouncing set on channel 1 then steady press.
        trans  = 0;
        pulses = 0;
        prev_q = q0[1];
        for (int i = 0; i < 25; i++) begin
            if (i < 5) begin
                set_n[1] = (i % 2 == 1) ? 1'b1 : 1'b0;
            end else begin
                set_n[1] = 1'b0;
            end
            tick(1);
            if (q0[1] !== prev_q) trans++;
            if (ch0[1] === 1'b1) pulses++;
            prev_q = q0[1];
        end
        check("bounce_trans", 2'(trans), 2'd1);
        check("bounce_pulses", 2'(pulses), 2'd1);
        check("bounce_q", q0, 2'b11);
        check("bounce_qn", qn0, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/btn_latch_bank.md
BTN_LATCH_BANK -- requirements
Module: btn_latch_bank

Interface
REQ-001 Parameter N_CH, default 2: number of independent set/reset latch channels (1..16).
REQ-002 Parameter DB_CYCLES, default 270000: debounce window in clock cycles (10 ms at 27 MHz); legal range 1..2^20.
REQ-003 Parameter BOTH_MODE, default 0: response when set and reset are both pressed; 0 = reset wins, 1 = set wins, 2 = hold.
REQ-004 clk  input  1  single system clock; all logic is on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 btn_set_n  input  N_CH  raw, asynchronous, active-low set buttons; one bit per channel.
REQ-007 btn_rst_n  input  N_CH  raw, asynchronous, active-low reset buttons; one bit per channel.
REQ-008 q  output  N_CH  registered latch state per channel.
REQ-009 q_n  output  N_CH  complement of q.
REQ-010 changed  output  N_CH  one-cycle pulse when the matching q bit toggles.

Function
REQ-011 Each of the 2*N_CH button inputs SHALL pass through a two-flop synchroniser before any other use.
REQ-012 Each synchronised input SHALL have its own debouncer: a counter plus a debounced level register.
REQ-013 The counter SHALL clear whenever the synchronised level equals the debounced level, and increment otherwise.
REQ-014 The debounced level SHALL take the synchronised value, and the counter SHALL clear, on the edge where the counter reaches DB_CYCLES-1 while a mismatch is still present.
REQ-015 A glitch shorter than DB_CYCLES cycles SHALL NOT change the debounced level.
REQ-016 The counter SHALL be $clog2(DB_CYCLES+1) bits wide and SHALL never wrap.
REQ-017 pressed = ~debounced level.
REQ-018 Latch update, registered, evaluated every cycle: set pressed only -> q=1; reset pressed only -> q=0; neither -> hold.
REQ-019 With both set and reset pressed, q SHALL follow BOTH_MODE.
REQ-020 q_n SHALL equal ~q in every cycle; the block has no forbidden state.
REQ-021 changed[i] SHALL be high for exactly the one cycle following the edge on which q[i] changed.
REQ-022 Latency: a clean level change on a button pin, held steady, SHALL reach q in exactly DB_CYCLES+3 clock edges, counted from the first edge that samples the new level.
REQ-023 Channels SHALL be fully independent; simultaneous events on different channels SHALL be processed in the same cycle.
REQ-024 An illegal BOTH_MODE value (3) SHALL behave as mode 0.

Reset
REQ-025 While rst is high: synchroniser and debounced registers = 1 (released), counters = 0, q = 0, q_n = all ones, changed = 0.
REQ-026 A reset asserted mid-debounce SHALL discard the partial count; a button still held after release of rst SHALL be re-qualified through the full DB_CYCLES window.
REQ-027 The first cycle after reset SHALL NOT pulse changed.

Structure
REQ-028 Package btn_latch_pkg SHALL hold the BOTH_MODE constants (MODE_RESET_WINS=0, MODE_SET_WINS=1, MODE_HOLD=2) and the default DB_CYCLES.
REQ-029 The synchroniser and debouncer SHALL form one sub-module, btn_debounce (parameter DB_CYCLES; ports clk, rst, btn_n, pressed), instantiated 2*N_CH times via generate.
REQ-030 Latch and changed logic SHALL live in the top level; target size is 150-250 lines total.

Verification (DB_CYCLES=4, N_CH=2)
REQ-031 Reset, then hold btn_set_n[0]=0 -> q[0] rises exactly 7 edges after the first sampling edge; changed[0] pulses once; q_n[0]=0.
REQ-032 Hold btn_set_n[0] low for 3 cycles only -> q[0] stays 0 and changed stays 0.
REQ-033 q[0]=1, press set and reset together: BOTH_MODE=0 -> q[0]=0; BOTH_MODE=1 -> q[0]=1; BOTH_MODE=2 -> q[0]=1 (held).
REQ-034 Press set[0] and reset[1] in the same cycle (q=2'b10 beforehand) -> q=2'b01 on the same edge; changed=2'b11 for one cycle.
REQ-035 Assert rst for 1 cycle, 2 cycles into a set press, with the button still held -> q=0 during reset; q rises exactly 7 edges after rst deasserts.
REQ-036 Bounce set[1] (0,1,0,1,0 per cycle), then hold low -> exactly one q[1] transition and one changed[1] pulse.
